bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
- Inverse direction of the BCD-to-hex datapath: converts a captured binary word back into packed BCD digits for display or readout.
- Sits between a binary register or counter stage and the digit display logic.
- Uses a START/BUSY/DONE handshake; one bit is processed per clock.

Parameters:
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; the elaboration check fails otherwise.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous reset, active low.
- START  input  1  conversion request; sampled on the rising edge of CLK.
- BIN_IN  input  BIN_W  binary operand; sampled only on the edge that accepts START.
- BUSY  output  1  high while a conversion is in progress (state != IDLE).
- DONE  output  1  one-cycle pulse; BCD_OUT is valid from this cycle onward.
- BCD_OUT  output  4*DIGITS  packed BCD result, digit 0 in bits [3:0]; registered and held until the next completion.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=IDLE; shift and BCD working registers=0; bit counter=0.
  - BUSY=0, DONE=0, BCD_OUT=0.
  - Reset mid-conversion aborts with no partial result; BCD_OUT reads 0.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - On an edge with START=1: load the binary shift register with BIN_IN, clear the BCD working register, set counter=BIN_W, go to SHIFT.
  - START=0: stay in IDLE.
- SHIFT, each edge:
  - Every 4-bit working digit >= 5 gets +3 (all digits in parallel, combinational).
  - Then {bcd_work, bin_shift} shifts left by 1; the binary MSB enters BCD bit 0.
  - counter decrements.
  - On the edge where counter==1 (the last shift): write the adjusted-and-shifted value into BCD_OUT and go to FINISH.
- FINISH: DONE=1 for exactly this cycle; next edge goes to IDLE.
- Timing, with START accepted at edge E0:
  - Shifts occur at edges E1..E_BIN_W.
  - BCD_OUT updates at edge E_BIN_W.
  - DONE is high between E_BIN_W and E_BIN_W+1.
  - BUSY goes high after E0 and low after E_BIN_W+1.
  - For defaults: 17 cycles from accept to IDLE.
- START while BUSY=1 (SHIFT or FINISH) is ignored. It is neither queued nor allowed to corrupt the result.
- Back-to-back: the earliest next accept is edge E_BIN_W+1 with START=1 at that edge. BUSY must then stay high with no gap.
- BIN_IN changes after the accept edge have no effect.
- Width rules:
  - Working digits never exceed 9 after adjust-and-shift.
  - The +3 adjust is 4-bit; no carry leaves a digit before the shift.
  - Maximum input 2^BIN_W-1 must produce only valid BCD (no digit > 9).
- DONE and BUSY are registered (decoded from the state register), not combinational from START.

Decomposition:
- Shared package bcd_pkg holds:
  - state enum {IDLE, SHIFT, FINISH};
  - BCD_DIGIT_W = 4, ADJ_THRESHOLD = 5, ADJ_ADD = 3;
  - a function computing the minimum DIGITS for a given BIN_W, used by the elaboration check.
- Sub-module bcd_digit_adjust: combinational 4-bit in/out (adds 3 if the input is >= 5). bin_to_bcd_seq instantiates it DIGITS times via generate.
- The counter is a local down-counter of width clog2(BIN_W+1).

Test Plan:
- BIN_IN=16'd0, START pulse -> DONE exactly 16 cycles after the accept edge, BCD_OUT=20'h00000, BUSY high 17 cycles.
- BIN_IN=16'd65535 -> BCD_OUT=20'h65535; BIN_IN=16'd1234 -> 20'h01234; BIN_IN=16'd9999 -> 20'h09999; BIN_IN=16'd10 -> 20'h00010.
- Accept 16'd500, then hold START=1 with BIN_IN=16'd777 through SHIFT -> first result 20'h00500. Because START is still high at edge E17, a second conversion is accepted there -> 20'h00777. Repeat the first part with START dropped before E17 -> no second DONE.
- Back-to-back: 42 accepted, then 43 accepted at E17 -> two DONE pulses 17 cycles apart, results 20'h00042 then 20'h00043. BCD_OUT holds 20'h00042 until the second completion.
- RST_N low for one cycle at shift 8 of a 16'd4321 conversion -> BUSY=0, DONE=0, BCD_OUT=0 immediately (asynchronous). A fresh START of 16'd4321 then gives 20'h04321.
- Random sweep of 1000 values plus an exhaustive sweep in a BIN_W=8, DIGITS=3 configuration -> BCD_OUT matches a decimal reference model; no digit > 9 ever appears.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_ADD       = 4'd3;

    // Smallest digit count whose decimal range covers 2^bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_val;
        longint unsigned pow10;
        int d;
        max_val = (64'd1 << bin_w) - 64'd1;
        pow10   = 64'd1;
        d       = 0;
        for (int i = 0; i < 20; i++) begin
            if (pow10 <= max_val) begin
                pow10 = pow10 * 64'd10;
                d++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so the following shift carries into the next digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din >= ADJ_THRESHOLD) ? din + ADJ_ADD : din;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// START/BUSY/DONE handshake with a registered, held BCD result.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          START,
    input  logic [BIN_W-1:0]              BIN_IN,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [BCD_DIGIT_W*DIGITS-1:0] BCD_OUT
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    generate
        if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
            $error("bin_to_bcd_seq: DIGITS=%0d cannot hold BIN_W=%0d", DIGITS, BIN_W);
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [BIN_W-1:0] bin_shift;
    logic [BCD_W-1:0] bcd_work;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_shifted;
    logic [BCD_W-1:0] bcd_out;
    logic [CNT_W-1:0] cnt;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .din  (bcd_work[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .dout (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    assign bcd_shifted = {bcd_adj[BCD_W-2:0], bin_shift[BIN_W-1]};

    // FINISH also accepts START so back-to-back conversions keep BUSY high.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_LAST) state_nxt = FINISH;
            end
            FINISH: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bin_shift <= '0;
            bcd_work  <= '0;
            bcd_out   <= '0;
            cnt       <= '0;
        end else if (accept) begin
            bin_shift <= BIN_IN;
            bcd_work  <= '0;
            cnt       <= CNT_LOAD;
        end else if (state == SHIFT) begin
            bin_shift <= {bin_shift[BIN_W-2:0], 1'b0};
            bcd_work  <= bcd_shifted;
            cnt       <= cnt - 1'b1;
            if (cnt == CNT_LAST) bcd_out <= bcd_shifted;
        end
    end

    assign BUSY    = (state != IDLE);
    assign DONE    = (state == FINISH);
    assign BCD_OUT = bcd_out;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed table, handshake corner sequences, random 16-bit sweep, exhaustive 8-bit sweep.
module tb_bin_to_bcd_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [15:0] BIN_IN;
    logic        BUSY;
    logic        DONE;
    logic [19:0] BCD_OUT;

    logic        START8;
    logic [7:0]  BIN8;
    logic        BUSY8;
    logic        DONE8;
    logic [11:0] BCD8;

    int nchk  = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BIN_IN(BIN_IN),
        .BUSY(BUSY), .DONE(DONE), .BCD_OUT(BCD_OUT)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(START8), .BIN_IN(BIN8),
        .BUSY(BUSY8), .DONE(DONE8), .BCD_OUT(BCD8)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Decimal reference: peel digits with div/mod.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int bad_digits(input logic [31:0] b, input int digits);
        int n;
        n = 0;
        for (int i = 0; i < digits; i++)
            if (b[4*i +: 4] > 4'd9) n++;
        return n;
    endfunction

    // Drives v1 as an accepted START, then watches 40 cycles. Window index i is the
    // falling edge after accept edge E_i; START driven at index i is seen at E_{i+1}.
    task automatic run_window(input logic [15:0] v1, input logic [15:0] v2,
                              input int raise_at, input int drop_at,
                              output int n_done, output int d0_at, output int d1_at,
                              output logic [19:0] d0_val, output logic [19:0] d1_val,
                              output logic [19:0] mid_val, output int busy_cnt,
                              output int busy_low);
        logic [39:0] busy_v;
        int last;
        n_done = 0; d0_at = -1; d1_at = -1;
        d0_val = '0; d1_val = '0; mid_val = '0;
        busy_cnt = 0; busy_low = 0; busy_v = '0;
        @(negedge CLK);
        START  = 1'b1;
        BIN_IN = v1;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                if (n_done == 0) begin d0_at = i; d0_val = BCD_OUT; end
                else if (n_done == 1) begin d1_at = i; d1_val = BCD_OUT; end
                n_done++;
            end
            busy_v[i] = BUSY;
            if (BUSY) busy_cnt++;
            if (i == 25) mid_val = BCD_OUT;
            START  = (i < drop_at) || (i == raise_at);
            BIN_IN = (raise_at >= 0 && i >= raise_at && START) ? v2 : 16'($urandom);
        end
        START = 1'b0;
        last = (d1_at >= 0) ? d1_at : d0_at;
        for (int i = 0; i <= last; i++)
            if (!busy_v[i]) busy_low++;
    endtask

    task automatic run16(input logic [15:0] v, output logic [19:0] res, output int lat);
        @(negedge CLK);
        START  = 1'b1;
        BIN_IN = v;
        @(negedge CLK);
        START  = 1'b0;
        BIN_IN = 16'($urandom);
        lat = 0;
        while (!DONE && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        res = BCD_OUT;
    endtask

    task automatic run8(input logic [7:0] v, output logic [11:0] res, output int lat);
        @(negedge CLK);
        START8 = 1'b1;
        BIN8   = v;
        @(negedge CLK);
        START8 = 1'b0;
        BIN8   = 8'($urandom);
        lat = 0;
        while (!DONE8 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        res = BCD8;
    endtask

    typedef struct {
        logic [15:0] bin;
        logic [19:0] bcd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int n_done, d0_at, d1_at, busy_cnt, busy_low, lat, lat_bad, bad, cnt_done;
        logic [19:0] d0_val, d1_val, mid_val, res;
        logic [11:0] res8;
        logic [15:0] rv;

        vecs[0] = '{16'd0,     20'h00000};
        vecs[1] = '{16'd65535, 20'h65535};
        vecs[2] = '{16'd1234,  20'h01234};
        vecs[3] = '{16'd9999,  20'h09999};
        vecs[4] = '{16'd10,    20'h00010};
        vecs[5] = '{16'd1,     20'h00001};
        vecs[6] = '{16'd100,   20'h00100};
        vecs[7] = '{16'd60000, 20'h60000};

        RST_N  = 1'b0;
        START  = 1'b0;
        BIN_IN = '0;
        START8 = 1'b0;
        BIN8   = '0;
        repeat (3) @(negedge CLK);
        check("reset_busy",  32'(BUSY),    32'd0);
        check("reset_done",  32'(DONE),    32'd0);
        check("reset_bcd",   32'(BCD_OUT), 32'd0);
        check("reset_busy8", 32'(BUSY8),   32'd0);
        check("reset_bcd8",  32'(BCD8),    32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 8; k++) begin
            run_window(vecs[k].bin, 16'd0, -1, 0, n_done, d0_at, d1_at,
                       d0_val, d1_val, mid_val, busy_cnt, busy_low);
            check($sformatf("vec%0d_ndone", k),   32'(n_done),   32'd1);
            check($sformatf("vec%0d_latency", k), 32'(d0_at),    32'd16);
            check($sformatf("vec%0d_bcd", k),     32'(d0_val),   32'(vecs[k].bcd));
            check($sformatf("vec%0d_busy", k),    32'(busy_cnt), 32'd17);
        end

        // START held through the conversion: ignored until the FINISH edge, then accepted.
        run_window(16'd500, 16'd777, 0, 17, n_done, d0_at, d1_at,
                   d0_val, d1_val, mid_val, busy_cnt, busy_low);
        check("hold_ndone",  32'(n_done),   32'd2);
        check("hold_d0_at",  32'(d0_at),    32'd16);
        check("hold_d0_val", 32'(d0_val),   32'h00500);
        check("hold_d1_at",  32'(d1_at),    32'd33);
        check("hold_d1_val", 32'(d1_val),   32'h00777);
        check("hold_gap",    32'(busy_low), 32'd0);

        run_window(16'd500, 16'd777, 0, 15, n_done, d0_at, d1_at,
                   d0_val, d1_val, mid_val, busy_cnt, busy_low);
        check("drop_ndone",  32'(n_done),   32'd1);
        check("drop_d0_val", 32'(d0_val),   32'h00500);
        check("drop_busy",   32'(busy_cnt), 32'd17);

        run_window(16'd42, 16'd43, 16, 0, n_done, d0_at, d1_at,
                   d0_val, d1_val, mid_val, busy_cnt, busy_low);
        check("b2b_ndone",  32'(n_done),   32'd2);
        check("b2b_d0_at",  32'(d0_at),    32'd16);
        check("b2b_d0_val", 32'(d0_val),   32'h00042);
        check("b2b_d1_at",  32'(d1_at),    32'd33);
        check("b2b_d1_val", 32'(d1_val),   32'h00043);
        check("b2b_hold",   32'(mid_val),  32'h00042);
        check("b2b_gap",    32'(busy_low), 32'd0);
        check("b2b_busy",   32'(busy_cnt), 32'd34);

        // Asynchronous reset mid-conversion.
        @(negedge CLK);
        START  = 1'b1;
        BIN_IN = 16'd4321;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        check("rst_pre_busy", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY),    32'd0);
        check("rst_done", 32'(DONE),    32'd0);
        check("rst_bcd",  32'(BCD_OUT), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DONE || BUSY) cnt_done++;
        end
        check("rst_no_resume", 32'(cnt_done), 32'd0);
        check("rst_bcd_held",  32'(BCD_OUT),  32'd0);
        run_window(16'd4321, 16'd0, -1, 0, n_done, d0_at, d1_at,
                   d0_val, d1_val, mid_val, busy_cnt, busy_low);
        check("rst_fresh_ndone", 32'(n_done), 32'd1);
        check("rst_fresh_bcd",   32'(d0_val), 32'h04321);

        lat_bad = 0;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            rv = 16'($urandom);
            run16(rv, res, lat);
            if (lat != 16) lat_bad++;
            bad += bad_digits(32'(res), 5);
            check($sformatf("rand16_%0d", rv), 32'(res), ref_bcd(32'(rv), 5));
        end
        check("rand16_latency", 32'(lat_bad), 32'd0);
        check("rand16_digits",  32'(bad),     32'd0);

        lat_bad = 0;
        bad = 0;
        for (int v = 0; v < 256; v++) begin
            run8(8'(v), res8, lat);
            if (lat != 8) lat_bad++;
            bad += bad_digits(32'(res8), 3);
            check($sformatf("exh8_%0d", v), 32'(res8), ref_bcd(v, 3));
        end
        check("exh8_latency", 32'(lat_bad), 32'd0);
        check("exh8_digits",  32'(bad),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
